line_clear_engine: RTL and testbench

- Downstream of the gameboard stage. After a piece locks into board RAM, this block scans the 30-row board and removes every complete row.
- It compacts all surviving rows toward the bottom (row 29) and zero-fills the vacated top rows.
- It reports the number of lines cleared to the scoring/level logic and maintains a running line total.
- It is the sole RAM master while busy; the gameboard stage must not access board RAM while busy=1.

---
 rtl/polytris_pkg.sv | 33 +++
 rtl/line_clear_engine_if.sv | 30 +++
 rtl/line_clear_engine_row_full_detect.sv | 18 +
 rtl/line_clear_engine.sv | 120 ++++++++++++
 tb/tb_line_clear_engine.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/polytris_pkg.sv
// Shared board geometry, cell encoding and line-clear FSM state types.
// Also holds the saturating adder used for the running line total.
package polytris_pkg;

    localparam int ROWS   = 30;
    localparam int COLS   = 16;
    localparam int CELL_W = 2;
    localparam int ROW_W  = COLS * CELL_W;
    localparam int ADDR_W = 5;
    localparam int TOT_W  = 16;
    localparam int CNT_W  = 5;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    typedef enum logic [CELL_W-1:0] {
        EMPTY   = 2'b00,
        CYAN    = 2'b01,
        MAGENTA = 2'b10,
        YELLOW  = 2'b11
    } cell_t;

    typedef enum logic [2:0] {
        IDLE, RD, EVAL, WR, FILL, DONE
    } lce_state_t;

    function automatic logic [TOT_W-1:0] sat_add(input logic [TOT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [TOT_W:0] s;
        s = {1'b0, a} + (TOT_W+1)'(b);
        return s[TOT_W] ? '1 : s[TOT_W-1:0];
    endfunction

endpackage

// File: rtl/line_clear_engine_if.sv
// Handshake, status and board-RAM bus between the line-clear engine and its host.
// master = engine side, slave = gameboard / RAM side.
interface line_clear_engine_if;
    import polytris_pkg::*;

    logic              start;
    logic              clr_total;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  lines_cleared;
    logic [TOT_W-1:0]  total_lines;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_re;
    logic              ram_we;
    logic [ROW_W-1:0]  ram_wdata;
    logic [ROW_W-1:0]  ram_rdata;

    modport master (
        input  start, clr_total, ram_rdata,
        output busy, done, lines_cleared, total_lines,
               ram_addr, ram_re, ram_we, ram_wdata
    );

    modport slave (
        output start, clr_total, ram_rdata,
        input  busy, done, lines_cleared, total_lines,
               ram_addr, ram_re, ram_we, ram_wdata
    );

endinterface

// File: rtl/line_clear_engine_row_full_detect.sv
// Combinational complete-row test: a row is full when every cell is non-EMPTY.
// Shared with the gameboard stage's own line check.
module row_full_detect
    import polytris_pkg::*;
(
    input  logic [ROW_W-1:0] row_i,
    output logic             full_o
);

    logic [COLS-1:0] occ;

    for (genvar k = 0; k < COLS; k++) begin : g_cell
        assign occ[k] = cell_t'(row_i[k*CELL_W +: CELL_W]) != EMPTY;
    end

    assign full_o = &occ;

endmodule

// File: rtl/line_clear_engine.sv
// Scans the board bottom-up, drops full rows by compacting survivors toward row
// ROWS-1, zero-fills the vacated top rows and keeps per-scan / running line counts.
module line_clear_engine
    import polytris_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    line_clear_engine_if.master  bus
);

    lce_state_t        state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROW_W-1:0]  row_buf_q, row_buf_d;
    logic [CNT_W-1:0]  lines_q, lines_d;
    logic [TOT_W-1:0]  total_q, total_d;
    logic              row_full;

    row_full_detect u_full (
        .row_i  (bus.ram_rdata),
        .full_o (row_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            row_buf_q <= '0;
            lines_q   <= '0;
            total_q   <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            row_buf_q <= row_buf_d;
            lines_q   <= lines_d;
            total_q   <= total_d;
        end
    end

    // Next state and pointer updates; rd_ptr only steps when another row remains.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        row_buf_d = row_buf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rd_ptr_d = LAST_ROW;
                    wr_ptr_d = LAST_ROW;
                    cnt_d    = '0;
                    state_d  = RD;
                end
            end
            RD: state_d = EVAL;
            EVAL: begin
                row_buf_d = bus.ram_rdata;
                if (!row_full && wr_ptr_q != rd_ptr_q) begin
                    state_d = WR;
                end else begin
                    if (row_full)              cnt_d    = cnt_q + CNT_W'(1);
                    else if (wr_ptr_q != '0)   wr_ptr_d = wr_ptr_q - ADDR_W'(1);
                    if (rd_ptr_q == '0) begin
                        state_d = (cnt_d != '0) ? FILL : DONE;
                    end else begin
                        rd_ptr_d = rd_ptr_q - ADDR_W'(1);
                        state_d  = RD;
                    end
                end
            end
            WR: begin
                if (wr_ptr_q != '0) wr_ptr_d = wr_ptr_q - ADDR_W'(1);
                if (rd_ptr_q == '0) begin
                    state_d = (cnt_q != '0) ? FILL : DONE;
                end else begin
                    rd_ptr_d = rd_ptr_q - ADDR_W'(1);
                    state_d  = RD;
                end
            end
            FILL: begin
                if (wr_ptr_q == '0) state_d  = DONE;
                else                wr_ptr_d = wr_ptr_q - ADDR_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A clear request in the same cycle as DONE takes priority over the add.
    always_comb begin
        lines_d = lines_q;
        total_d = total_q;
        if (state_q == DONE) begin
            lines_d = cnt_q;
            total_d = sat_add(total_q, cnt_q);
        end
        if (bus.clr_total) total_d = '0;
    end

    always_comb begin
        bus.busy          = state_q != IDLE;
        bus.done          = state_q == DONE;
        bus.ram_re        = state_q == RD;
        bus.ram_we        = (state_q == WR) || (state_q == FILL);
        bus.ram_addr      = (state_q == RD) ? rd_ptr_q : wr_ptr_q;
        bus.ram_wdata     = (state_q == WR) ? row_buf_q : '0;
        bus.lines_cleared = lines_q;
        bus.total_lines   = total_q;
    end

endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: board RAM model plus a queue-based compaction model.
module tb_line_clear_engine;
    import polytris_pkg::*;

    typedef logic [ROW_W-1:0] board_t [ROWS];

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    line_clear_engine_if u_if();

    line_clear_engine dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if)
    );

    always #5 clk = ~clk;

    board_t mem, init_b;
    bit     load_b = 1'b0;
    int     wr_cnt = 0, done_cnt = 0, both_cnt = 0;
    int     total = 0, bad = 0;
    int     exp_total = 0;

    always @(posedge clk) begin
        if (load_b) mem <= init_b;
        else if (u_if.ram_we) mem[u_if.ram_addr] <= u_if.ram_wdata;
        if (u_if.ram_re) u_if.ram_rdata <= mem[u_if.ram_addr];
        if (u_if.ram_we) wr_cnt <= wr_cnt + 1;
        if (u_if.done) done_cnt <= done_cnt + 1;
        if (u_if.ram_we && u_if.ram_re) both_cnt <= both_cnt + 1;
    end

    function automatic bit is_full(input logic [ROW_W-1:0] r);
        for (int k = 0; k < COLS; k++)
            if (r[2*k +: 2] == 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [ROW_W-1:0] rand_full();
        logic [ROW_W-1:0] r;
        for (int k = 0; k < COLS; k++) r[2*k +: 2] = 2'($urandom_range(1, 3));
        return r;
    endfunction

    // Reference: survivors keep their bottom-up order, stacked from the last row.
    task automatic model(input board_t b, output board_t eb, output int lines,
                         output int cyc, output int writes);
        logic [ROW_W-1:0] kept[$];
        int f;
        f = 0; cyc = 1; writes = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (is_full(b[r])) begin
                f++; cyc += 2;
            end else begin
                kept.push_back(b[r]);
                cyc += (f > 0) ? 3 : 2;
                if (f > 0) writes++;
            end
        end
        cyc += f; writes += f; lines = f;
        for (int r = 0; r < ROWS; r++) eb[r] = '0;
        foreach (kept[i]) eb[ROWS-1-i] = kept[i];
    endtask

    task automatic load(input board_t b);
        @(negedge clk);
        init_b = b; load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
    endtask

    // Pulses start, counts cycles to done; optionally re-pulses start mid-scan.
    task automatic run_scan(input int extra_at, output int cyc, output bit to);
        @(negedge clk); u_if.start = 1'b1;
        @(negedge clk); u_if.start = 1'b0;
        cyc = 1; to = 1'b0;
        while (u_if.done !== 1'b1) begin
            if (cyc >= 3000) begin to = 1'b1; break; end
            @(negedge clk); cyc++;
            u_if.start = (cyc == extra_at);
        end
        @(negedge clk); u_if.start = 1'b0;
    endtask

    task automatic test_reset();
        u_if.start = 1'b0; u_if.clr_total = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        total++; if (u_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", u_if.busy); end
        total++; if (u_if.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", u_if.done); end
        total++; if ({u_if.ram_re, u_if.ram_we} !== 2'b00) begin bad++; $display("FAIL reset_ram_en: got %0b want 00", {u_if.ram_re, u_if.ram_we}); end
        total++; if (u_if.total_lines !== '0 || u_if.lines_cleared !== '0) begin bad++; $display("FAIL reset_counts: got %0h/%0h want 0/0", u_if.total_lines, u_if.lines_cleared); end
        reset_n = 1'b1;
    endtask

    task automatic test_empty();
        board_t b; int cyc, w0; bit to;
        for (int r = 0; r < ROWS; r++) b[r] = '0;
        load(b); w0 = wr_cnt;
        run_scan(-1, cyc, to);
        total++; if (to) begin bad++; $display("FAIL empty_timeout: got no done want done"); end
        total++; if (cyc != 61) begin bad++; $display("FAIL empty_latency: got %0d want 61", cyc); end
        total++; if (wr_cnt - w0 != 0) begin bad++; $display("FAIL empty_writes: got %0d want 0", wr_cnt - w0); end
        total++; if (u_if.lines_cleared !== 5'd0) begin bad++; $display("FAIL empty_lines: got %0d want 0", u_if.lines_cleared); end
        total++; if (u_if.total_lines !== 16'(exp_total)) begin bad++; $display("FAIL empty_total: got %0d want %0d", u_if.total_lines, exp_total); end
    endtask

    task automatic test_one_full();
        board_t b; int cyc, w0; bit to;
        for (int r = 0; r < ROWS; r++) b[r] = '0;
        b[29] = rand_full(); b[28] = 32'h0000_0003;
        load(b); w0 = wr_cnt;
        run_scan(-1, cyc, to);
        exp_total += 1;
        total++; if (to) begin bad++; $display("FAIL one_timeout: got no done want done"); end
        total++; if (mem[29] !== 32'h0000_0003) begin bad++; $display("FAIL one_row29: got %h want 00000003", mem[29]); end
        total++; if (mem[0] !== '0) begin bad++; $display("FAIL one_row0: got %h want 0", mem[0]); end
        total++; if (u_if.lines_cleared !== 5'd1) begin bad++; $display("FAIL one_lines: got %0d want 1", u_if.lines_cleared); end
        total++; if (wr_cnt - w0 != 30) begin bad++; $display("FAIL one_writes: got %0d want 30", wr_cnt - w0); end
    endtask

    task automatic test_four_full();
        board_t b; int cyc, nz; bit to;
        for (int r = 0; r < ROWS; r++) b[r] = '0;
        for (int r = 26; r < 30; r++) b[r] = rand_full();
        b[25] = 32'h5555_0000;
        load(b);
        run_scan(-1, cyc, to);
        exp_total += 4;
        nz = 0;
        for (int r = 0; r < 4; r++) if (mem[r] !== '0) nz++;
        total++; if (to) begin bad++; $display("FAIL four_timeout: got no done want done"); end
        total++; if (mem[29] !== 32'h5555_0000) begin bad++; $display("FAIL four_row29: got %h want 55550000", mem[29]); end
        total++; if (nz != 0) begin bad++; $display("FAIL four_top_zero: got %0d nonzero rows want 0", nz); end
        total++; if (u_if.lines_cleared !== 5'd4) begin bad++; $display("FAIL four_lines: got %0d want 4", u_if.lines_cleared); end
        total++; if (u_if.total_lines !== 16'(exp_total)) begin bad++; $display("FAIL four_total: got %0d want %0d", u_if.total_lines, exp_total); end
    endtask

    task automatic test_two_split();
        board_t b, eb; int cyc, lines, ecyc, ew; bit to;
        logic [ROW_W-1:0] ra, rb;
        ra = ($urandom & 32'h3FFF_FFFF) | 32'h1;
        rb = ($urandom & 32'h3FFF_FFFF) | 32'h4;
        for (int r = 0; r < ROWS; r++) b[r] = '0;
        b[29] = rand_full(); b[27] = rand_full(); b[28] = ra; b[26] = rb;
        model(b, eb, lines, ecyc, ew);
        load(b);
        run_scan(-1, cyc, to);
        exp_total += 2;
        total++; if (to) begin bad++; $display("FAIL split_timeout: got no done want done"); end
        total++; if (mem[29] !== ra || mem[28] !== rb) begin bad++; $display("FAIL split_rows: got %h/%h want %h/%h", mem[29], mem[28], ra, rb); end
        total++; if (mem[0] !== '0 || mem[1] !== '0) begin bad++; $display("FAIL split_top: got %h/%h want 0/0", mem[0], mem[1]); end
        total++; if (u_if.lines_cleared !== 5'd2) begin bad++; $display("FAIL split_lines: got %0d want 2", u_if.lines_cleared); end
        total++; if (cyc != ecyc) begin bad++; $display("FAIL split_latency: got %0d want %0d", cyc, ecyc); end
    endtask

    task automatic test_random();
        board_t b, eb; int cyc, lines, ecyc, ew, w0, badrow; bit to;
        for (int it = 0; it < 10; it++) begin
            for (int r = 0; r < ROWS; r++) begin
                case ($urandom_range(0, 3))
                    0, 1: b[r] = rand_full();
                    2:    b[r] = '0;
                    default: b[r] = $urandom;
                endcase
            end
            if (it == 9) for (int r = 0; r < ROWS; r++) b[r] = rand_full();
            model(b, eb, lines, ecyc, ew);
            load(b); w0 = wr_cnt;
            run_scan(-1, cyc, to);
            exp_total += lines;
            badrow = -1;
            for (int r = ROWS - 1; r >= 0; r--) if (mem[r] !== eb[r]) badrow = r;
            total++; if (to) begin bad++; $display("FAIL rand%0d_timeout: got no done want done", it); end
            total++; if (badrow >= 0) begin bad++; $display("FAIL rand%0d_board: row %0d got %h want %h", it, badrow, mem[badrow], eb[badrow]); end
            total++; if (u_if.lines_cleared !== 5'(lines)) begin bad++; $display("FAIL rand%0d_lines: got %0d want %0d", it, u_if.lines_cleared, lines); end
            total++; if (u_if.total_lines !== 16'(exp_total)) begin bad++; $display("FAIL rand%0d_total: got %0d want %0d", it, u_if.total_lines, exp_total); end
            total++; if (cyc != ecyc) begin bad++; $display("FAIL rand%0d_latency: got %0d want %0d", it, cyc, ecyc); end
            total++; if (wr_cnt - w0 != ew) begin bad++; $display("FAIL rand%0d_writes: got %0d want %0d", it, wr_cnt - w0, ew); end
        end
        total++; if (both_cnt != 0) begin bad++; $display("FAIL re_we_exclusive: got %0d overlaps want 0", both_cnt); end
    endtask

    task automatic test_saturate();
        board_t b; int cyc, d0; bit to;
        for (int r = 0; r < ROWS; r++) b[r] = (r >= 26) ? rand_full() : '0;
        @(negedge clk);
        force dut.total_q = 16'hFFFE;
        @(negedge clk);
        release dut.total_q;
        load(b); d0 = done_cnt;
        run_scan(20, cyc, to);
        total++; if (to) begin bad++; $display("FAIL sat_timeout: got no done want done"); end
        total++; if (u_if.total_lines !== 16'hFFFF) begin bad++; $display("FAIL sat_total: got %h want ffff", u_if.total_lines); end
        repeat (100) @(negedge clk);
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL busy_start_ignored: got %0d dones want 1", done_cnt - d0); end
        total++; if (u_if.busy !== 1'b0) begin bad++; $display("FAIL busy_after_ignore: got %0b want 0", u_if.busy); end
        u_if.clr_total = 1'b1; @(negedge clk); u_if.clr_total = 1'b0;
        total++; if (u_if.total_lines !== '0) begin bad++; $display("FAIL clr_total: got %h want 0", u_if.total_lines); end
        load(b);
        u_if.clr_total = 1'b1;
        run_scan(-1, cyc, to);
        u_if.clr_total = 1'b0;
        exp_total = 0;
        total++; if (u_if.total_lines !== '0) begin bad++; $display("FAIL clr_vs_done: got %h want 0", u_if.total_lines); end
    endtask

    task automatic test_reset_mid();
        board_t b; int cyc, k; bit to;
        for (int r = 0; r < ROWS; r++) b[r] = '0;
        b[29] = rand_full(); b[28] = 32'h0000_0003;
        load(b);
        @(negedge clk); u_if.start = 1'b1;
        @(negedge clk); u_if.start = 1'b0;
        k = 0;
        while (u_if.ram_we !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        total++; if (k >= 200) begin bad++; $display("FAIL mid_wr_seen: got no write want write"); end
        reset_n = 1'b0; #1;
        total++; if ({u_if.busy, u_if.done, u_if.ram_we, u_if.ram_re} !== 4'b0000) begin bad++; $display("FAIL mid_reset_outs: got %b want 0000", {u_if.busy, u_if.done, u_if.ram_we, u_if.ram_re}); end
        total++; if (u_if.total_lines !== '0 || u_if.lines_cleared !== '0) begin bad++; $display("FAIL mid_reset_counts: got %0h/%0h want 0/0", u_if.total_lines, u_if.lines_cleared); end
        @(negedge clk); reset_n = 1'b1;
        exp_total = 0;
        for (int r = 0; r < ROWS; r++) b[r] = '0;
        b[29] = rand_full();
        load(b);
        run_scan(-1, cyc, to);
        total++; if (to) begin bad++; $display("FAIL mid_restart_timeout: got no done want done"); end
        total++; if (u_if.lines_cleared !== 5'd1 || u_if.total_lines !== 16'd1) begin bad++; $display("FAIL mid_restart_counts: got %0d/%0d want 1/1", u_if.lines_cleared, u_if.total_lines); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_one_full();
        test_four_full();
        test_two_split();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
